// File: rtl/params.sv
// Shared word, state and buffer-entry types for the instruction fetch slice.
package params;
  typedef logic [31:0] word;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN   = 1'b0;
  localparam fetch_state_t FAULT = 1'b1;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    word pc;
    word instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a push is visible at the head one cycle later (no bypass).
// Latency 1 cycle; a push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, credit-limited imem requests, registered decode buffer (rsp->dec 1 cycle); redirect flushes.
// Requests stall while inflight+buffered reaches BUF_DEPTH; optional misaligned-redirect trap under FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import params::*;
#(
  parameter word RESET_PC  = 32'h0000_0000,
  parameter int  BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic redirect_valid,
  input  word  redirect_addr,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output word  imem_req_addr,
  input  logic imem_rsp_valid,
  input  word  imem_rsp_data,
  output logic dec_valid,
  input  logic dec_ready,
  output word  dec_instr,
  output word  dec_pc,
  output logic fetch_fault
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  word              pc;
  word              target;
  word              shadow_pc;
  fetch_state_t     state;
  fetch_entry_t     buf_in, buf_head;
  logic [CNT_W-1:0] inflight, discard, buf_count, shadow_count;
  logic             req_hs, rsp_keep, dec_pop;
  logic             buf_empty, buf_full, shadow_empty, shadow_full;
  logic             unused_status;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target = redirect_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else if (redirect_valid)
      state <= (redirect_addr[1:0] != 2'b00) ? FAULT : RUN;
  end

  assign fetch_fault = (state == FAULT);
`else
  assign target      = redirect_addr & ~32'h3;
  assign state       = RUN;
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                          (({1'b0, inflight} + {1'b0, buf_count}) < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (discard == '0);
  assign dec_pop        = dec_valid && dec_ready;

  assign buf_in    = '{pc: shadow_pc, instr: imem_rsp_data};
  assign dec_valid = !buf_empty;
  assign dec_instr = buf_head.instr;
  assign dec_pc    = buf_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        pc <= target;
        // inflight already includes responses marked stale, so everything still outstanding becomes stale.
        discard <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_hs) pc <= pc + word'(INSTR_BYTES);
        if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_entry_t))) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .push_dat (buf_in),
    .pop      (dec_pop),
    .head_dat (buf_head),
    .count    (buf_count),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  // PCs of live (non-stale) requests, popped in step with their responses.
  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(word))) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (req_hs),
    .push_dat (pc),
    .pop      (rsp_keep),
    .head_dat (shadow_pc),
    .count    (shadow_count),
    .empty    (shadow_empty),
    .full     (shadow_full)
  );

  assign unused_status = ^{buf_full, shadow_full, shadow_empty, shadow_count};
endmodule
